demux8_stream: RTL and testbench

//   Registered 1-to-8 stream demultiplexer with a valid/ready handshake. It is the

---
 rtl/demux8_stream_if.sv | 25 ++
 rtl/demux8_stream.sv | 47 ++++
 tb/tb_demux8_stream.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/demux8_stream_if.sv
// rtl/demux8_stream_if.sv - producer and eight-lane consumer handshake bundle for demux8_stream
interface demux8_stream_if #(
   parameter int WIDTH = 8
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [2:0]       in_sel;
   logic             in_bcast;
   logic [7:0]       out_valid;
   logic [7:0]       out_ready;
   logic [WIDTH-1:0] out_data;
   logic             busy;

   // master: the surrounding environment (producer plus consumers)
   modport master (
      output in_valid, in_data, in_sel, in_bcast, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_data, in_sel, in_bcast, out_ready,
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/demux8_stream.sv
// rtl/demux8_stream.sv - registered 1-to-8 stream demultiplexer with per-lane valid/ready
module demux8_stream #(
   parameter int WIDTH    = 8,
   parameter bit BCAST_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   demux8_stream_if.slave bus
);
   logic [WIDTH-1:0] data_q, data_d;
   logic [7:0]       pend_q, pend_d;
   logic [7:0]       remain;
   logic             accept;

   // Lanes still owed the held word after this cycle's handshakes.
   assign remain       = pend_q & ~bus.out_ready;
   assign bus.in_ready = (remain == 8'h00);
   assign accept       = bus.in_valid & bus.in_ready;

   // Input fields are only looked at on accept, so X on them while idle stays out of state.
   always_comb begin
      pend_d = remain;
      data_d = data_q;
      if (accept) begin
         data_d = bus.in_data;
         if (BCAST_EN && bus.in_bcast) begin
            pend_d = 8'hFF;
         end else begin
            pend_d = 8'h01 << bus.in_sel;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= 8'h00;
         data_q <= {WIDTH{1'b0}};
      end else begin
         pend_q <= pend_d;
         data_q <= data_d;
      end
   end

   assign bus.out_valid = pend_q;
   assign bus.out_data  = data_q;
   assign bus.busy      = |pend_q;
endmodule

// File: tb/tb_demux8_stream.sv
// tb/tb_demux8_stream.sv - scoreboard bench for demux8_stream with randomized traffic
module tb_demux8_stream;
   localparam int W = 8;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   demux8_stream_if #(.WIDTH(W)) b0 ();
   demux8_stream_if #(.WIDTH(W)) b1 ();

   demux8_stream #(.WIDTH(W), .BCAST_EN(1'b1)) u0 (.clk(clk), .rst(rst), .bus(b0));
   demux8_stream #(.WIDTH(W), .BCAST_EN(1'b0)) u1 (.clk(clk), .rst(rst), .bus(b1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: queue of words in flight, each with the set of lanes still owed it.
   typedef struct {
      logic [W-1:0] data;
      logic [7:0]   lanes;
   } word_t;
   word_t sb[$];

   always @(negedge clk) begin
      logic [7:0] owed;
      logic       mready;
      word_t      w;
      owed = (sb.size() != 0) ? sb[0].lanes : 8'h00;
      if (rst) begin
         sb.delete();
      end else begin
         chk("sb_out_valid", b0.out_valid, owed);
         mready = ((owed & ~b0.out_ready) == 8'h00);
         chk("sb_in_ready", 8'(b0.in_ready), 8'(mready));
         chk("sb_busy", 8'(b0.busy), 8'(owed != 8'h00));
         if (owed != 8'h00) chk("sb_out_data", b0.out_data, sb[0].data);
         if (sb.size() != 0) begin
            sb[0].lanes = sb[0].lanes & ~b0.out_ready;
            if (sb[0].lanes == 8'h00) void'(sb.pop_front());
         end
         if (b0.in_valid && mready) begin
            w.data  = b0.in_data;
            w.lanes = b0.in_bcast ? 8'hFF : (8'h01 << b0.in_sel);
            sb.push_back(w);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      b0.in_valid = 1'b1; b0.in_data = 8'h55; b0.in_sel = 3'd3; b0.in_bcast = 1'b0;
      b0.out_ready = 8'h00;
      b1.in_valid = 1'b1; b1.in_data = 8'h55; b1.in_sel = 3'd3; b1.in_bcast = 1'b0;
      b1.out_ready = 8'h00;
      step();
      step();
      rst = 1'b0;
      b0.in_valid = 1'b0;
      b1.in_valid = 1'b0;
      #1;
      chk("rst_out_valid", b0.out_valid, 8'h00);
      chk("rst_busy", 8'(b0.busy), 8'h00);
      chk("rst_out_data", b0.out_data, 8'h00);
      chk("rst_in_ready", 8'(b0.in_ready), 8'h01);
      chk("rst_u1_out_valid", b1.out_valid, 8'h00);

      // broadcast flag ignored when BCAST_EN=0
      b1.in_valid = 1'b1; b1.in_bcast = 1'b1; b1.in_sel = 3'd6; b1.in_data = 8'h11;
      step();
      b1.in_valid = 1'b0; b1.in_bcast = 1'b0;
      #1;
      chk("nobc_out_valid", b1.out_valid, 8'h40);
      chk("nobc_out_data", b1.out_data, 8'h11);

      // unicast with consumer stalled
      b0.in_valid = 1'b1; b0.in_data = 8'hA5; b0.in_sel = 3'd3; b0.in_bcast = 1'b0;
      b0.out_ready = 8'h00;
      step();
      b0.in_valid = 1'b0;
      #1;
      chk("uni_out_valid", b0.out_valid, 8'h08);
      chk("uni_out_data", b0.out_data, 8'hA5);
      chk("uni_in_ready", 8'(b0.in_ready), 8'h00);
      b0.out_ready = 8'h08;
      #1;
      chk("uni_in_ready_drain", 8'(b0.in_ready), 8'h01);
      step();
      chk("uni_done_valid", b0.out_valid, 8'h00);
      chk("uni_done_busy", 8'(b0.busy), 8'h00);

      // back-to-back unicast across every lane
      b0.out_ready = 8'hFF;
      for (int k = 0; k < 8; k++) begin
         b0.in_valid = 1'b1; b0.in_sel = 3'(k); b0.in_data = 8'(k + 1);
         #1;
         chk("b2b_in_ready", 8'(b0.in_ready), 8'h01);
         step();
         chk("b2b_out_valid", b0.out_valid, 8'h01 << k);
         chk("b2b_out_data", b0.out_data, 8'(k + 1));
      end
      b0.in_valid = 1'b0;
      step();
      chk("b2b_empty", b0.out_valid, 8'h00);

      // broadcast drained in three groups, next word taken on the final drain edge
      b0.out_ready = 8'h00;
      b0.in_valid = 1'b1; b0.in_bcast = 1'b1; b0.in_data = 8'h3C;
      step();
      b0.in_valid = 1'b0; b0.in_bcast = 1'b0;
      #1;
      chk("bc_all", b0.out_valid, 8'hFF);
      b0.out_ready = 8'h0F;
      #1;
      chk("bc_ready0", 8'(b0.in_ready), 8'h00);
      step();
      chk("bc_f0", b0.out_valid, 8'hF0);
      chk("bc_data_hold", b0.out_data, 8'h3C);
      b0.out_ready = 8'h30;
      #1;
      chk("bc_ready1", 8'(b0.in_ready), 8'h00);
      step();
      chk("bc_c0", b0.out_valid, 8'hC0);
      b0.out_ready = 8'hC0;
      b0.in_valid = 1'b1; b0.in_data = 8'h77; b0.in_sel = 3'd2;
      #1;
      chk("bc_ready_last", 8'(b0.in_ready), 8'h01);
      step();
      b0.in_valid = 1'b0;
      #1;
      chk("bc_next_valid", b0.out_valid, 8'h04);
      chk("bc_next_data", b0.out_data, 8'h77);
      b0.out_ready = 8'h04;
      step();
      chk("bc_next_done", b0.out_valid, 8'h00);

      // other lanes' ready cannot release lane 5; reset discards it
      b0.out_ready = 8'hDF;
      b0.in_valid = 1'b1; b0.in_sel = 3'd5; b0.in_data = 8'h9A;
      step();
      b0.in_valid = 1'b0;
      #1;
      chk("mid_hold0", b0.out_valid, 8'h20);
      step();
      step();
      chk("mid_hold2", b0.out_valid, 8'h20);
      chk("mid_in_ready", 8'(b0.in_ready), 8'h00);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", b0.out_valid, 8'h00);
      chk("mid_rst_in_ready", 8'(b0.in_ready), 8'h01);

      // randomized traffic, checked by the scoreboard monitor
      for (int n = 0; n < 600; n++) begin
         b0.in_valid = ($urandom_range(0, 3) != 0);
         if (b0.in_valid) begin
            b0.in_data  = 8'($urandom);
            b0.in_sel   = 3'($urandom_range(0, 7));
            b0.in_bcast = ($urandom_range(0, 5) == 0);
         end else begin
            b0.in_data  = 'x;
            b0.in_sel   = 'x;
            b0.in_bcast = 1'bx;
         end
         b0.out_ready = (n % 50 < 10) ? 8'hFF : 8'($urandom);
         step();
      end
      b0.in_valid = 1'b0; b0.in_bcast = 1'b0; b0.in_sel = 3'd0; b0.in_data = 8'h00;
      b0.out_ready = 8'hFF;
      step();
      step();
      step();
      chk("final_sb_empty", 8'(sb.size()), 8'h00);
      chk("final_busy", 8'(b0.busy), 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
